// File: rtl/instr_word_arbiter.sv
// Round-robin arbiter with bounded bursts feeding one registered instruction-word slot.
// Requesters and downstream both use valid/ready; one word per clock when not stalled.
package instr_word_arbiter_pkg;
    localparam int unsigned WORD_W = 72;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [7:0]  opcode;
    } instruction_word_t;
endpackage

module instr_word_arbiter
    import instr_word_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 1,
    parameter int unsigned SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WORD_W-1:0]   req_word,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [WORD_W-1:0]           out_word,
    output logic [SRC_W-1:0]            out_src,
    input  logic                        out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    instruction_word_t word_q, word_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [SRC_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic              load_en;
    logic              burst_go;
    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;
    logic [WORD_W-1:0] sel_word;
    logic              xfer;

    // Grant: continue the owner's burst, else rotate starting just after the owner.
    always_comb begin
        load_en   = (state_q == ST_EMPTY) || out_ready;
        // burst_cnt of zero means no owner yet, so requester 0 wins first after reset
        burst_go  = (burst_cnt_q != '0) && req_valid[owner_q]
                    && (burst_cnt_q < CNT_W'(MAX_BURST));
        grant_vld = 1'b0;
        grant_idx = '0;
        if (burst_go) begin
            grant_vld = 1'b1;
            grant_idx = owner_q;
        end else begin
            // Scan from farthest to nearest so the nearest valid candidate wins.
            for (int k = int'(NUM_REQ); k >= 1; k--) begin
                if (req_valid[SRC_W'((int'(owner_q) + k) % int'(NUM_REQ))]) begin
                    grant_vld = 1'b1;
                    grant_idx = SRC_W'((int'(owner_q) + k) % int'(NUM_REQ));
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_word  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = resetN && load_en && grant_vld && (grant_idx == SRC_W'(i));
            if (grant_idx == SRC_W'(i)) begin
                sel_word = req_word[i*WORD_W +: WORD_W];
            end
        end
        xfer = |(req_valid & req_ready);
    end

    // Next-state for the output slot and burst tracking.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        src_d       = src_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (xfer) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (xfer) begin
            word_d  = sel_word;
            src_d   = grant_idx;
            owner_d = grant_idx;
            // A lone owner re-granted at its limit starts a fresh burst.
            if ((grant_idx == owner_q) && (burst_cnt_q < CNT_W'(MAX_BURST))) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end else begin
                burst_cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_EMPTY;
            word_q      <= '0;
            src_q       <= '0;
            owner_q     <= SRC_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            src_q       <= src_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_word  = word_q;
    assign out_src   = src_q;

endmodule

// File: doc/instr_word_arbiter.md
# instr_word_arbiter

Round-robin arbiter that shares one instruction-word output register between `NUM_REQ` requesters, each presenting a 72-bit `instruction_word_t` word (`address[31:0]`, `data[31:0]`, `opcode[7:0]`, packed in that order, MSB first). It sits in front of the instruction register stage. It arbitrates with valid/ready handshakes on both sides, supports bounded bursts per requester, and sustains one word per clock when the output is not back-pressured.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `MAX_BURST`, default 1: maximum consecutive words granted to one requester while others wait, legal range 1..15. A value of 1 gives pure round-robin.
- `SRC_W`, default `$clog2(NUM_REQ)`: width of the source index.

Ports:
- `clock`  input  1: single clock; all state updates on the rising edge.
- `resetN`  input  1: asynchronous, active-low reset.
- `req_valid`  input  NUM_REQ: per-requester word valid.
- `req_word`  input  NUM_REQ*72: flattened words; requester i occupies bits [72*i+71 : 72*i].
- `req_ready`  output  NUM_REQ: per-requester accept; at most one bit set.
- `out_valid`  output  1: output register holds a word.
- `out_word`  output  72: held instruction word.
- `out_src`  output  SRC_W: index of the requester that supplied `out_word`.
- `out_ready`  input  1: downstream accept.

## Operation
- Output register: `out_valid`, `out_word`, `out_src`. There are two states:
  - EMPTY (`out_valid` = 0).
  - FULL (`out_valid` = 1).
- `load_en` = !`out_valid` || `out_ready`.
- Transitions:
  - EMPTY→FULL on any request transfer.
  - FULL→EMPTY on `out_ready` with no new transfer.
  - FULL→FULL on `out_ready` with a simultaneous transfer, which replaces the word in the same edge.
- Grant selection happens each cycle, combinationally, and only when `load_en` = 1:
  - Burst continuation: if `owner` is valid, `req_valid[owner]` = 1, and `burst_cnt` < `MAX_BURST`, grant `owner`.
  - Otherwise, grant the first valid requester searching `owner`+1, `owner`+2, … with wrap-around modulo `NUM_REQ`. The previous owner is searched last.
  - If no requester is valid, there is no grant.
- `req_ready[i]` = `load_en` && grant == i. `req_ready` is forced to 0 while `resetN` = 0.
- Transfer is `req_valid[i]` && `req_ready[i]`. On a transfer:
  - `out_word` ← `req_word[i]`.
  - `out_src` ← i.
  - `out_valid` ← 1.
  - `burst_cnt` ← (i == `owner`) ? `burst_cnt`+1 : 1.
  - `owner` ← i.
- The burst ends when the owner drops `req_valid` or `burst_cnt` reaches `MAX_BURST`. The next transfer to any other requester restarts `burst_cnt` at 1.
- If the owner is the only valid requester when its burst limit is reached, it is re-granted with no bubble, and `burst_cnt` restarts at 1.
- While FULL and `out_ready` = 0: `out_word` and `out_src` are held stable and all `req_ready` are 0.
- The block never inspects or modifies `opcode`, `address` or `data`.
- Reset values: `out_valid` = 0, `out_word` = 0, `out_src` = 0, `owner` = `NUM_REQ`-1 (so requester 0 has first priority), `burst_cnt` = 0.
- Reset asserted mid-operation clears the state immediately and discards any held word. No transfer is reported for that word.

## Timing
- Latency is 1 clock from a request transfer edge to `out_valid` = 1 with that word.
- Throughput is one word per clock while `out_ready` is held at 1 and any requester is valid.
- `req_ready` depends combinationally on `req_valid`, `out_valid`, `out_ready` and internal state. Requesters must not derive `req_valid` from `req_ready`.
- `resetN` falling clears all registers asynchronously; outputs reach their reset values without a clock edge. Deassertion is sampled on the next rising `clock`.
- A requester that drops `req_valid` before a transfer loses nothing; no state is kept for it.

## Test plan
- **Reset:** hold `resetN`=0 with `req_valid`=4'b1111 → `req_ready`=0, `out_valid`=0, `out_word`=0; after release, the first transfer goes to requester 0 and `out_src`=0 one clock later.
- **Round-robin:** with `MAX_BURST`=1, all four requesters continuously valid and `out_ready`=1 → `out_src` sequence is 0,1,2,3,0,1, one word per clock with no bubbles.
- **Burst:** with `MAX_BURST`=2 and all valid → `out_src` sequence is 0,0,1,1,2,2,3,3,0; if requester 1 drops valid after one word, the sequence is 0,0,1,2,2.
- **Back-pressure:** requester 2 sends {address 32'hFFFF1000, data 32'h00000032, opcode 8'h11}, then `out_ready`=0 for 3 clocks → `out_word` is stable at that value, `out_src`=2, all `req_ready`=0; on `out_ready`=1 the next word is loaded the same edge.
- **Lone requester:** with `MAX_BURST`=3 and only requester 3 valid for 7 words → 7 consecutive outputs with `out_src`=3, no idle cycles.
- **Mid-operation reset:** assert `resetN`=0 asynchronously while `out_valid`=1 → `out_valid`=0 before the next clock edge, `out_word`=0, and priority returns to requester 0 after release.
